// File: rtl/decode_probe_checker.sv
// Decode probe checker: re-encodes decode-stage fields, compares with fetch.
// Ports: clk/reset, en + f_* fetch probes, d_* decode probes, counters, first-error capture.
//
// Purpose
//   Passive monitor. A delay line of fetched {valid, pc, insn} is aligned with
//   the decode probes. The decoded fields are rebuilt into an RV32I word and
//   compared with the fetched word; the PCs are compared as well.
//
// Ports
//   clk, reset (sync, active-high)
//   en, f_pc, f_insn          fetch probes, pushed into the delay line
//   d_pc, d_opcode .. d_shamt decode probes, aligned with the delay-line tail
//   chk_count, err_count, unk_count   saturating counters
//   mism_pulse, err_sticky            mismatch flags
//   first_err_pc/exp/got              capture of the first mismatch
module decode_probe_checker #(
  parameter int FD_LAT = 1,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [31:0]   f_pc,
  input  logic [31:0]   f_insn,
  input  logic [31:0]   d_pc,
  input  logic [6:0]    d_opcode,
  input  logic [4:0]    d_rd,
  input  logic [2:0]    d_funct3,
  input  logic [4:0]    d_rs1,
  input  logic [4:0]    d_rs2,
  input  logic [6:0]    d_funct7,
  input  logic [31:0]   d_imm,
  input  logic [4:0]    d_shamt,
  output logic [CW-1:0] chk_count,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] unk_count,
  output logic          mism_pulse,
  output logic          err_sticky,
  output logic [31:0]   first_err_pc,
  output logic [31:0]   first_err_exp,
  output logic [31:0]   first_err_got
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [FD_LAT-1:0]       dv_q, dv_d;
  logic [FD_LAT-1:0][31:0] dpc_q, dpc_d;
  logic [FD_LAT-1:0][31:0] dins_q, dins_d;

  always_comb begin
    dv_d      = dv_q;
    dpc_d     = dpc_q;
    dins_d    = dins_q;
    dv_d[0]   = en;
    dpc_d[0]  = f_pc;
    dins_d[0] = f_insn;
    for (int i = 1; i < FD_LAT; i++) begin
      dv_d[i]   = dv_q[i-1];
      dpc_d[i]  = dpc_q[i-1];
      dins_d[i] = dins_q[i-1];
    end
  end

  logic        is_r, is_i, is_sh, is_s;
  logic        is_b, is_u, is_j;
  logic        sup;
  logic [31:0] enc;

  always_comb begin
    is_sh = (d_opcode == OP_IMM) &&
            ((d_funct3 == 3'b001) || (d_funct3 == 3'b101));
    is_r  = d_opcode == OP_R;
    is_i  = ((d_opcode == OP_IMM) || (d_opcode == OP_LD) ||
             (d_opcode == OP_JALR) || (d_opcode == OP_SYS)) && !is_sh;
    is_s  = d_opcode == OP_ST;
    is_b  = d_opcode == OP_BR;
    is_u  = (d_opcode == OP_LUI) || (d_opcode == OP_AUI);
    is_j  = d_opcode == OP_JAL;
    enc   = '0;
    sup   = 1'b1;
    unique case (1'b1)
      is_r:  enc = {d_funct7, d_rs2, d_rs1, d_funct3, d_rd, d_opcode};
      is_sh: enc = {d_funct7, d_shamt, d_rs1, d_funct3, d_rd, d_opcode};
      is_i:  enc = {d_imm[11:0], d_rs1, d_funct3, d_rd, d_opcode};
      is_s:  enc = {d_imm[11:5], d_rs2, d_rs1, d_funct3,
                    d_imm[4:0], d_opcode};
      is_b:  enc = {d_imm[12], d_imm[10:5], d_rs2, d_rs1, d_funct3,
                    d_imm[4:1], d_imm[11], d_opcode};
      is_u:  enc = {d_imm[31:12], d_rd, d_opcode};
      is_j:  enc = {d_imm[20], d_imm[10:1], d_imm[11], d_imm[19:12],
                    d_rd, d_opcode};
      default: sup = 1'b0;
    endcase
  end

  logic [CW-1:0] chk_q, chk_d;
  logic [CW-1:0] err_q, err_d;
  logic [CW-1:0] unk_q, unk_d;
  logic          pulse_q, pulse_d;
  logic          sticky_q, sticky_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   fexp_q, fexp_d;
  logic [31:0]   fgot_q, fgot_d;

  logic          tail_v;
  logic [31:0]   tail_pc, tail_ins;
  logic          do_chk, do_unk, mism;

  always_comb begin
    tail_v   = dv_q[FD_LAT-1];
    tail_pc  = dpc_q[FD_LAT-1];
    tail_ins = dins_q[FD_LAT-1];
    do_chk   = tail_v && sup;
    do_unk   = tail_v && !sup;
    // PC and word mismatch in one slot collapse to a single error
    mism     = do_chk && ((enc != tail_ins) || (d_pc != tail_pc));

    chk_d    = chk_q;
    err_d    = err_q;
    unk_d    = unk_q;
    if (do_chk && (chk_q != '1)) chk_d = chk_q + CW'(1);
    if (mism && (err_q != '1))   err_d = err_q + CW'(1);
    if (do_unk && (unk_q != '1)) unk_d = unk_q + CW'(1);

    pulse_d  = mism;
    sticky_d = sticky_q | mism;
    fpc_d    = fpc_q;
    fexp_d   = fexp_q;
    fgot_d   = fgot_q;
    if (mism && !sticky_q) begin
      fpc_d  = d_pc;
      fexp_d = tail_ins;
      fgot_d = enc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dv_q     <= '0;
      dpc_q    <= '0;
      dins_q   <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      unk_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      fpc_q    <= '0;
      fexp_q   <= '0;
      fgot_q   <= '0;
    end else begin
      dv_q     <= dv_d;
      dpc_q    <= dpc_d;
      dins_q   <= dins_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      unk_q    <= unk_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      fpc_q    <= fpc_d;
      fexp_q   <= fexp_d;
      fgot_q   <= fgot_d;
    end
  end

  assign chk_count     = chk_q;
  assign err_count     = err_q;
  assign unk_count     = unk_q;
  assign mism_pulse    = pulse_q;
  assign err_sticky    = sticky_q;
  assign first_err_pc  = fpc_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_decode_probe_checker.sv
// Bench for decode_probe_checker.
// Fetch slots are queued when driven and turned into decode probes next cycle.
module tb_decode_probe_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] f_pc, f_insn, d_pc, d_imm;
  logic [6:0]  d_opcode, d_funct7;
  logic [4:0]  d_rd, d_rs1, d_rs2, d_shamt;
  logic [2:0]  d_funct3;

  logic [15:0] chk_a, err_a, unk_a;
  logic        pulse_a, sticky_a;
  logic [31:0] fpc_a, fexp_a, fgot_a;
  logic [3:0]  chk_b, err_b, unk_b;
  logic        pulse_b, sticky_b;
  logic [31:0] fpc_b, fexp_b, fgot_b;

  always #5 clk = ~clk;

  decode_probe_checker #(.FD_LAT(1), .CW(16)) dut (
    .clk(clk), .reset(reset), .en(en),
    .f_pc(f_pc), .f_insn(f_insn), .d_pc(d_pc),
    .d_opcode(d_opcode), .d_rd(d_rd), .d_funct3(d_funct3),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_funct7(d_funct7),
    .d_imm(d_imm), .d_shamt(d_shamt),
    .chk_count(chk_a), .err_count(err_a), .unk_count(unk_a),
    .mism_pulse(pulse_a), .err_sticky(sticky_a),
    .first_err_pc(fpc_a), .first_err_exp(fexp_a),
    .first_err_got(fgot_a)
  );

  decode_probe_checker #(.FD_LAT(1), .CW(4)) dut_sat (
    .clk(clk), .reset(reset), .en(en),
    .f_pc(f_pc), .f_insn(f_insn), .d_pc(d_pc),
    .d_opcode(d_opcode), .d_rd(d_rd), .d_funct3(d_funct3),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_funct7(d_funct7),
    .d_imm(d_imm), .d_shamt(d_shamt),
    .chk_count(chk_b), .err_count(err_b), .unk_count(unk_b),
    .mism_pulse(pulse_b), .err_sticky(sticky_b),
    .first_err_pc(fpc_b), .first_err_exp(fexp_b),
    .first_err_got(fgot_b)
  );

  // cor: 0 clean, 1 imm+1, 2 pc+4, 3 imm=shamt (no error expected)
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] insn;
    int          cor;
    logic [31:0] got;
  } slot_t;

  slot_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  int          m_chk, m_err, m_unk;
  logic        m_pulse, m_sticky;
  logic [31:0] m_fpc, m_fexp, m_fgot;

  function automatic logic [31:0] sat(input int x, input int m);
    return (x > m) ? 32'(m) : 32'(x);
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
      7'h23, 7'h63, 7'h37, 7'h17, 7'h6F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("chk_count", 32'(chk_a), sat(m_chk, 65535));
    chk("err_count", 32'(err_a), sat(m_err, 65535));
    chk("unk_count", 32'(unk_a), sat(m_unk, 65535));
    chk("mism_pulse", 32'(pulse_a), 32'(m_pulse));
    chk("err_sticky", 32'(sticky_a), 32'(m_sticky));
    chk("first_err_pc", fpc_a, m_fpc);
    chk("first_err_exp", fexp_a, m_fexp);
    chk("first_err_got", fgot_a, m_fgot);
    chk("sat_chk", 32'(chk_b), sat(m_chk, 15));
    chk("sat_err", 32'(err_b), sat(m_err, 15));
    chk("sat_unk", 32'(unk_b), sat(m_unk, 15));
  endtask

  task automatic garbage_d();
    d_pc     = $urandom;
    d_opcode = 7'($urandom);
    d_rd     = 5'($urandom);
    d_funct3 = 3'($urandom);
    d_rs1    = 5'($urandom);
    d_rs2    = 5'($urandom);
    d_funct7 = 7'($urandom);
    d_imm    = $urandom;
    d_shamt  = 5'($urandom);
  endtask

  task automatic drive_d(input slot_t h);
    logic [31:0] w;
    if (!h.v) begin
      garbage_d();
      return;
    end
    w        = h.insn;
    d_pc     = h.pc;
    d_opcode = w[6:0];
    d_rd     = w[11:7];
    d_funct3 = w[14:12];
    d_rs1    = w[19:15];
    d_rs2    = w[24:20];
    d_funct7 = w[31:25];
    d_shamt  = w[24:20];
    case (w[6:0])
      7'h23:   d_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:   d_imm = {{19{w[31]}}, w[31], w[7], w[30:25],
                        w[11:8], 1'b0};
      7'h37,
      7'h17:   d_imm = {w[31:12], 12'h000};
      7'h6F:   d_imm = {{11{w[31]}}, w[31], w[19:12], w[20],
                        w[30:21], 1'b0};
      default: d_imm = {{20{w[31]}}, w[31:20]};
    endcase
    case (h.cor)
      1: d_imm = d_imm + 32'd1;
      2: d_pc  = d_pc + 32'd4;
      3: d_imm = {27'd0, w[24:20]};
      default: ;
    endcase
    if (known_op(d_opcode)) begin
      m_chk++;
      if (h.cor == 1 || h.cor == 2) begin
        m_err++;
        m_pulse = 1'b1;
        if (!m_sticky) begin
          m_sticky = 1'b1;
          m_fpc    = d_pc;
          m_fexp   = h.insn;
          m_fgot   = h.got;
        end
      end
    end else begin
      m_unk++;
    end
  endtask

  task automatic tick(input logic e, input logic [31:0] pc,
                      input logic [31:0] insn, input int cor,
                      input logic [31:0] got);
    slot_t h;
    h = '{v: 1'b0, pc: '0, insn: '0, cor: 0, got: '0};
    if (sb.size() > 0) h = sb.pop_front();
    m_pulse = 1'b0;
    drive_d(h);
    en     = e;
    f_pc   = pc;
    f_insn = insn;
    sb.push_back('{v: e, pc: pc, insn: insn, cor: cor, got: got});
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    en     = 1'b1;
    f_pc   = $urandom;
    f_insn = $urandom;
    garbage_d();
    @(posedge clk);
    #1;
    sb.delete();
    m_chk = 0; m_err = 0; m_unk = 0;
    m_pulse = 1'b0; m_sticky = 1'b0;
    m_fpc = '0; m_fexp = '0; m_fgot = '0;
    check_all();
    reset = 1'b0;
  endtask

  task automatic clean_stream(input int bad_sw);
    tick(1, 32'h100, 32'h00500093, 0, 0);
    tick(1, 32'h104, 32'h002081B3, 0, 0);
    tick(1, 32'h108, 32'h0020A423, bad_sw, 32'h0020A4A3);
    tick(1, 32'h10C, 32'hFE000EE3, 0, 0);
    tick(1, 32'h110, 32'h0000006F, 0, 0);
    tick(1, 32'h114, 32'h123452B7, 0, 0);
    tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    f_pc = '0;
    f_insn = '0;
    garbage_d();

    // reset values; the first tick after reset sees garbage D probes
    do_reset();
    clean_stream(0);
    chk("clean_chk6", 32'(chk_a), 32'd6);
    chk("clean_err0", 32'(err_a), 32'd0);

    // sw immediate corrupted to 9
    do_reset();
    clean_stream(1);
    chk("imm_err1", 32'(err_a), 32'd1);
    chk("imm_got", fgot_a, 32'h0020A4A3);
    chk("imm_pc", fpc_a, 32'h108);

    // PC-only mismatch, then a second error that must not recapture
    do_reset();
    tick(1, 32'h200, 32'h00500093, 2, 32'h00500093);
    tick(1, 32'h204, 32'h002081B3, 0, 0);
    tick(1, 32'h208, 32'h0020A423, 1, 32'h0020A4A3);
    tick(0, 0, 0, 0, 0);
    chk("pc_err2", 32'(err_a), 32'd2);
    chk("pc_got_eq_exp", fgot_a, 32'h00500093);

    // enable low for three slots, then mid-stream reset
    do_reset();
    tick(1, 32'h300, 32'h00500093, 0, 0);
    tick(0, 32'h304, 32'h002081B3, 0, 0);
    tick(0, 32'h308, 32'h002081B3, 0, 0);
    tick(0, 32'h30C, 32'h002081B3, 0, 0);
    tick(1, 32'h310, 32'h002081B3, 2, 32'h002081B3);
    tick(1, 32'h314, 32'h00500093, 0, 0);
    chk("en_chk2", 32'(chk_a), 32'd2);
    do_reset();
    tick(0, 0, 0, 0, 0);

    // fence is unsupported; shifts go through funct7/shamt
    do_reset();
    tick(1, 32'h400, 32'h0FF0000F, 0, 0);
    tick(1, 32'h404, 32'h40315213, 3, 0);
    tick(1, 32'h408, 32'h00311093, 3, 0);
    tick(1, 32'h40C, 32'h40315213, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("fence_unk1", 32'(unk_a), 32'd1);
    chk("shift_chk3", 32'(chk_a), 32'd3);

    // saturation of the 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++)
      tick(1, 32'h500 + 32'(i * 4), 32'h00500093, 2, 32'h00500093);
    tick(0, 0, 0, 0, 0);
    chk("sat_err15", 32'(err_b), 32'd15);
    chk("sat_chk15", 32'(chk_b), 32'd15);
    chk("wide_err20", 32'(err_a), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
